// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types and widths for the VGA/CPU single-port RAM arbiter.
// Holds the arbiter state encoding and the wait-counter width.
package vga_mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int WAIT_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_MEM,
        ST_CAPT
    } arb_state_t;

endpackage

// File: rtl/vga_mem_arbiter.sv
// Shares one synchronous RAM between the VGA text master (absolute priority) and a CPU slave port.
// CPU ack 4 cycles after cs on an idle bus; each VGA-blocked cycle adds one; VGA is never stalled.
module vga_mem_arbiter
    import vga_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_vga_addr,
    input  logic              i_vga_cs,
    input  logic              i_vga_access,
    output logic [DATA_W-1:0] o_vga_dat,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_dat,
    input  logic              i_cpu_cs,
    input  logic              i_cpu_we,
    output logic [DATA_W-1:0] o_cpu_dat,
    output logic              o_cpu_ack,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_dat,
    output logic              o_mem_cs,
    output logic              o_mem_we,
    input  logic [DATA_W-1:0] i_mem_dat,
    output logic              o_starve_err
);

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [WAIT_CNT_W-1:0] STARVE_CNT = WAIT_CNT_W'(STARVE_LIMIT);

    arb_state_t              state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   cnt_nxt;
    logic [ADDR_W-1:0]       lat_addr;
    logic [DATA_W-1:0]       lat_dat;
    logic                    lat_we;
    logic                    free;

    // A cycle is only safe for the CPU if VGA neither uses it nor claims the next one.
    assign free      = ~i_vga_cs & ~i_vga_access;
    assign cnt_nxt   = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + WAIT_CNT_W'(1);
    assign o_vga_dat = i_mem_dat;

    always_comb begin
        o_mem_cs   = 1'b0;
        o_mem_we   = 1'b0;
        o_mem_addr = '0;
        o_mem_dat  = '0;
        if (i_vga_cs) begin
            o_mem_cs   = 1'b1;
            o_mem_addr = i_vga_addr;
        end else if (state == ST_MEM) begin
            o_mem_cs   = 1'b1;
            o_mem_we   = lat_we;
            o_mem_addr = lat_addr;
            o_mem_dat  = lat_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            lat_addr     <= '0;
            lat_dat      <= '0;
            lat_we       <= 1'b0;
            o_cpu_dat    <= '0;
            o_cpu_ack    <= 1'b0;
            o_starve_err <= 1'b0;
        end else begin
            o_cpu_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // cs is still high during the ack cycle; that is the old request.
                    if (i_cpu_cs && !o_cpu_ack) begin
                        lat_addr <= i_cpu_addr;
                        lat_dat  <= i_cpu_dat;
                        lat_we   <= i_cpu_we;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (free) begin
                        state <= ST_MEM;
                    end else begin
                        wait_cnt <= cnt_nxt;
                        if (cnt_nxt >= STARVE_CNT) begin
                            o_starve_err <= 1'b1;
                        end
                    end
                end
                ST_MEM: begin
                    // Unannounced VGA cs stole the RAM this cycle: retry.
                    state <= i_vga_cs ? ST_WAIT : ST_CAPT;
                end
                ST_CAPT: begin
                    if (!lat_we) begin
                        o_cpu_dat <= i_mem_dat;
                    end
                    o_cpu_ack <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a one-cycle-latency RAM model.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit after negedge.
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] vga_addr;
    logic        vga_cs;
    logic        vga_access;
    logic [15:0] vga_dat;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdat;
    logic        cpu_cs;
    logic        cpu_we;
    logic [15:0] cpu_rdat;
    logic        cpu_ack;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdat;
    logic        mem_cs;
    logic        mem_we;
    logic [15:0] mem_rdat = '0;
    logic        starve_err;

    logic        pre_en;
    logic [15:0] pre_a;
    logic [15:0] pre_d;
    logic [15:0] ram [0:65535];

    int total = 0;
    int bad   = 0;
    int cpu_mem_n = 0;
    int ack_n = 0;
    int base, mbase, mem_x, ack_x;

    vga_mem_arbiter dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_vga_addr   (vga_addr),
        .i_vga_cs     (vga_cs),
        .i_vga_access (vga_access),
        .o_vga_dat    (vga_dat),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_dat    (cpu_wdat),
        .i_cpu_cs     (cpu_cs),
        .i_cpu_we     (cpu_we),
        .o_cpu_dat    (cpu_rdat),
        .o_cpu_ack    (cpu_ack),
        .o_mem_addr   (mem_addr),
        .o_mem_dat    (mem_wdat),
        .o_mem_cs     (mem_cs),
        .o_mem_we     (mem_we),
        .i_mem_dat    (mem_rdat),
        .o_starve_err (starve_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_a] <= pre_d;
        end else if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdat;
            else        mem_rdat      <= ram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_cs && !vga_cs) cpu_mem_n++;
        if (cpu_ack) ack_n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        step();
        pre_en = 1'b0;
    endtask

    // Single CPU access on a quiet VGA bus; cs held through the ack cycle.
    task automatic cpu_basic(input string tag, input logic [15:0] a, input logic [15:0] d,
                             input logic we, input logic [15:0] exp_rd);
        step();
        cpu_cs   = 1'b1;
        cpu_addr = a;
        cpu_wdat = d;
        cpu_we   = we;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            if (k == 5) cpu_cs = 1'b0;
            probe();
            chk({tag, "_memcs"}, mem_cs, k == 2);
            chk({tag, "_ack"}, cpu_ack, k == 4);
            if (k == 2) begin
                chk({tag, "_addr"}, mem_addr, a);
                chk({tag, "_we"}, mem_we, we);
                if (we) chk({tag, "_wdat"}, mem_wdat, d);
            end
            if (k == 4) chk({tag, "_rdat"}, cpu_rdat, exp_rd);
        end
    endtask

    initial begin
        reset = 1'b1;
        vga_addr = '0; vga_cs = 1'b0; vga_access = 1'b0;
        cpu_addr = '0; cpu_wdat = '0; cpu_cs = 1'b0; cpu_we = 1'b0;
        pre_en = 1'b0; pre_a = '0; pre_d = '0;
        step();
        preload(16'h1234, 16'hBEEF);
        preload(16'h3000, 16'h3333);
        preload(16'h4000, 16'h4444);
        preload(16'h5000, 16'h5555);
        preload(16'h0100, 16'h1111);
        preload(16'h0101, 16'h2222);
        preload(16'h6000, 16'h0000);
        preload(16'h2000, 16'h0000);
        probe();
        chk("rst_ack", cpu_ack, 0);
        chk("rst_rdat", cpu_rdat, 0);
        chk("rst_err", starve_err, 0);
        chk("rst_memcs", mem_cs, 0);
        chk("rst_memwe", mem_we, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_memdat", mem_wdat, 0);
        step();
        reset = 1'b0;

        cpu_basic("rd", 16'h1234, 16'h0000, 1'b0, 16'hBEEF);
        cpu_basic("wr", 16'h2000, 16'h00A5, 1'b1, 16'hBEEF);
        chk("wr_ram", ram[16'h2000], 16'h00A5);

        // VGA 8-clock pattern, CPU read issued at x=3.
        base = ack_n; mem_x = -1; ack_x = -1;
        for (int x = 0; x < 16; x++) begin
            int ph;
            ph = x % 8;
            step();
            vga_access = (ph == 3) || (ph == 5);
            vga_cs     = (ph == 4) || (ph == 6);
            vga_addr   = (ph == 4) ? 16'h0100 : (ph == 6) ? 16'h0101 : 16'h0000;
            if (x == 3) begin
                cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
            end
            if (ack_x >= 0 && x == ack_x + 1) cpu_cs = 1'b0;
            probe();
            if (mem_cs && !vga_cs && mem_x < 0) mem_x = x;
            if (cpu_ack) begin
                ack_x = x;
                chk("pat_rdat", cpu_rdat, 16'h3333);
            end
            if (vga_cs) begin
                chk("pat_vaddr", mem_addr, vga_addr);
                chk("pat_vwe", mem_we, 0);
            end
            if (ph == 5) chk("pat_vdat5", vga_dat, 16'h1111);
            if (ph == 7) chk("pat_vdat7", vga_dat, 16'h2222);
        end
        chk("pat_memx", mem_x, 8);
        chk("pat_ackx", ack_x, 10);
        chk("pat_acks", ack_n - base, 1);
        vga_cs = 1'b0; vga_access = 1'b0; vga_addr = '0;

        // Starvation: access held high for 20 cycles.
        for (int k = 0; k < 25; k++) begin
            step();
            vga_access = (k < 20);
            if (k == 0) begin
                cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4000;
            end
            if (k == 24) cpu_cs = 1'b0;
            probe();
            chk("stv_err", starve_err, k >= 16);
            chk("stv_ack", cpu_ack, k == 23);
            if (k == 23) chk("stv_rdat", cpu_rdat, 16'h4444);
        end

        // Unannounced VGA cs on the cycle the CPU would own.
        base = ack_n; mbase = cpu_mem_n;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) begin
                cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
            end
            vga_cs   = (k == 2);
            vga_addr = (k == 2) ? 16'h0100 : 16'h0000;
            if (k == 7) cpu_cs = 1'b0;
            probe();
            if (k == 2) begin
                chk("vio_cs", mem_cs, 1);
                chk("vio_addr", mem_addr, 16'h0100);
                chk("vio_we", mem_we, 0);
            end
            if (k == 3) chk("vio_vdat", vga_dat, 16'h1111);
            if (k == 4) begin
                chk("vio_retry_cs", mem_cs, 1);
                chk("vio_retry_addr", mem_addr, 16'h5000);
            end
            chk("vio_ack", cpu_ack, k == 6);
            if (k == 6) chk("vio_rdat", cpu_rdat, 16'h5555);
        end
        chk("vio_acks", ack_n - base, 1);
        chk("vio_cpumem", cpu_mem_n - mbase, 1);

        // Reset while blocked in WAIT (error flag already set).
        base = ack_n; mbase = cpu_mem_n;
        for (int k = 0; k < 24; k++) begin
            step();
            vga_access = (k < 17);
            if (k == 0) begin
                cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6000; cpu_wdat = 16'h6666;
            end
            if (k == 17) begin
                reset = 1'b1; cpu_cs = 1'b0;
            end
            if (k == 18) reset = 1'b0;
            probe();
            if (k == 17) chk("rw_err_pre", starve_err, 1);
            if (k == 18) begin
                chk("rw_err", starve_err, 0);
                chk("rw_ack", cpu_ack, 0);
                chk("rw_memcs", mem_cs, 0);
            end
        end
        chk("rw_acks", ack_n - base, 0);
        chk("rw_cpumem", cpu_mem_n - mbase, 0);
        chk("rw_ram", ram[16'h6000], 16'h0000);

        // Reset during the MEM cycle.
        base = ack_n; mbase = cpu_mem_n;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 0) begin
                cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h6000; cpu_wdat = 16'h6666;
            end
            if (k == 2) begin
                reset = 1'b1; cpu_cs = 1'b0;
            end
            if (k == 3) reset = 1'b0;
            probe();
            if (k == 2) begin
                chk("rm_inmem", mem_cs, 1);
                mbase = cpu_mem_n;
            end
            if (k == 3) begin
                chk("rm_memcs", mem_cs, 0);
                chk("rm_ack", cpu_ack, 0);
                chk("rm_err", starve_err, 0);
            end
        end
        chk("rm_acks", ack_n - base, 0);
        chk("rm_cpumem", cpu_mem_n - mbase, 0);

        cpu_basic("post", 16'h1234, 16'h0000, 1'b0, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
